// File: rtl/screen_draw_controller.sv
`default_nettype none
// ============================================================================
// Module      : screen_draw_controller
// Description : Full-frame image sequencer for the VGA pixel-write port.
//               A one-cycle start request sweeps every pixel of the frame in
//               raster order, addresses the selected screen ROM, lines the
//               returned colour up with its coordinates and issues one
//               vga_plot per pixel.
// Ports       : clock, reset_n (synchronous, active-low)
//               start, screen_sel      - draw request and screen choice
//               busy, done             - frame in progress / end-of-frame pulse
//               rom_sel, rom_addr      - ROM mux select and pixel index
//               rom_data               - colour returned by the selected ROM
//               vga_x, vga_y, vga_colour, vga_plot - pixel write to adapter
// Revision    : 1.0 - initial release
// ============================================================================
module screen_draw_controller #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int ROM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  screen_sel,
  output logic        busy,
  output logic        done,
  output logic [1:0]  rom_sel,
  output logic [14:0] rom_addr,
  input  logic [2:0]  rom_data,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  localparam logic [7:0] c_last_x    = 8'(WIDTH - 1);
  localparam logic [6:0] c_last_y    = 7'(HEIGHT - 1);
  localparam logic [1:0] c_sel_clear = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;

  // Column/row counters run in lockstep with rom_addr so no multiply is needed.
  logic [7:0] r_x;
  logic [6:0] r_y;

  // Alignment pipeline: each entry carries the coordinates of the address
  // presented ROM_LATENCY cycles earlier, so the last stage lines up with
  // the rom_data for that address.
  logic [ROM_LATENCY-1:0] r_pipe_valid;
  logic [7:0]             r_pipe_x [ROM_LATENCY];
  logic [6:0]             r_pipe_y [ROM_LATENCY];

  logic w_last_index;
  logic w_sweep_valid;

  assign w_last_index  = (r_x == c_last_x) && (r_y == c_last_y);
  assign w_sweep_valid = (r_state == S_SWEEP);

  // Frame sequencing, address generation and status outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_sel  <= 2'd0;
      rom_addr <= 15'd0;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_SWEEP;
            busy     <= 1'b1;
            rom_sel  <= screen_sel;
            rom_addr <= 15'd0;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
          end
        end
        S_SWEEP: begin
          if (w_last_index) begin
            // Final index stays on rom_addr while the pipeline drains.
            r_state <= S_DRAIN;
          end else begin
            rom_addr <= rom_addr + 15'd1;
            if (r_x == c_last_x) begin
              r_x <= 8'd0;
              r_y <= r_y + 7'd1;
            end else begin
              r_x <= r_x + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          // Once the pipeline is empty the last plot is on the output this
          // cycle, so done lands on the cycle right after it.
          if (!(|r_pipe_valid)) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Latency alignment and the registered pixel-write port.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pipe_valid <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        r_pipe_x[i] <= 8'd0;
        r_pipe_y[i] <= 7'd0;
      end
      vga_plot   <= 1'b0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
    end else begin
      r_pipe_valid[0] <= w_sweep_valid;
      r_pipe_x[0]     <= r_x;
      r_pipe_y[0]     <= r_y;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_x[i]     <= r_pipe_x[i-1];
        r_pipe_y[i]     <= r_pipe_y[i-1];
      end
      vga_plot <= r_pipe_valid[ROM_LATENCY-1];
      if (r_pipe_valid[ROM_LATENCY-1]) begin
        vga_x      <= r_pipe_x[ROM_LATENCY-1];
        vga_y      <= r_pipe_y[ROM_LATENCY-1];
        // The clear screen ignores whatever the ROM mux happens to return.
        vga_colour <= (rom_sel == c_sel_clear) ? 3'd0 : rom_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_screen_draw_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_screen_draw_controller
// Description : Self-checking bench for screen_draw_controller. Two instances
//               run side by side, one with a 1-cycle ROM and one with a
//               2-cycle ROM. Expected outputs are computed per cycle from the
//               frame timing rules and the pixel index arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_draw_controller;

  localparam int NPIX = 19200;
  localparam int W    = 160;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [1:0] screen_sel = 2'd0;

  logic        busy_a, done_a, plot_a, busy_b, done_b, plot_b;
  logic [1:0]  rsel_a, rsel_b;
  logic [14:0] addr_a, addr_b;
  logic [2:0]  rdata_a, rdata_b, rstage_b, col_a, col_b;
  logic [7:0]  x_a, x_b;
  logic [6:0]  y_a, y_b;

  int asserts = 0;
  int fails   = 0;

  int rmode [2];
  int rom_tab [NPIX];

  int e_busy [2], e_done [2], e_addr [2], e_plot [2], e_xy [2], e_col [2], e_sel [2];
  int n_plot [2], n_done [2], off [2], sel_exp [2];

  always #5 clock = ~clock;

  screen_draw_controller #(.WIDTH(160), .HEIGHT(120), .ROM_LATENCY(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .screen_sel(screen_sel),
    .busy(busy_a), .done(done_a), .rom_sel(rsel_a), .rom_addr(addr_a),
    .rom_data(rdata_a), .vga_x(x_a), .vga_y(y_a), .vga_colour(col_a),
    .vga_plot(plot_a)
  );

  screen_draw_controller #(.WIDTH(160), .HEIGHT(120), .ROM_LATENCY(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .screen_sel(screen_sel),
    .busy(busy_b), .done(done_b), .rom_sel(rsel_b), .rom_addr(addr_b),
    .rom_data(rdata_b), .vga_x(x_b), .vga_y(y_b), .vga_colour(col_b),
    .vga_plot(plot_b)
  );

  // ROM contents: 0 = low address bits, 1 = all ones, 2 = random table.
  function automatic logic [2:0] col_of(input int m, input int n);
    if (m == 0) return 3'(n % 8);
    if (m == 1) return 3'b111;
    return 3'(rom_tab[n]);
  endfunction

  always @(posedge clock) begin
    rdata_a  <= col_of(rmode[0], int'(addr_a));
    rstage_b <= col_of(rmode[1], int'(addr_b));
    rdata_b  <= rstage_b;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".busy_a"}, int'(busy_a), 0);  chk({tag, ".busy_b"}, int'(busy_b), 0);
    chk({tag, ".done_a"}, int'(done_a), 0);  chk({tag, ".done_b"}, int'(done_b), 0);
    chk({tag, ".plot_a"}, int'(plot_a), 0);  chk({tag, ".plot_b"}, int'(plot_b), 0);
    chk({tag, ".rsel_a"}, int'(rsel_a), 0);  chk({tag, ".rsel_b"}, int'(rsel_b), 0);
    chk({tag, ".addr_a"}, int'(addr_a), 0);  chk({tag, ".addr_b"}, int'(addr_b), 0);
    chk({tag, ".x_a"}, int'(x_a), 0);        chk({tag, ".x_b"}, int'(x_b), 0);
    chk({tag, ".y_a"}, int'(y_a), 0);        chk({tag, ".y_b"}, int'(y_b), 0);
    chk({tag, ".col_a"}, int'(col_a), 0);    chk({tag, ".col_b"}, int'(col_b), 0);
  endtask

  // Compare one instance against the expected frame behaviour for cycle r
  // after the edge that accepted its start (r = 1 is the first busy cycle).
  task automatic check_cycle(input int d, input int r);
    int lat, n, ea;
    logic [2:0]  ec;
    logic        sb, sd, sp;
    logic [1:0]  ss;
    logic [14:0] sa;
    logic [7:0]  sx;
    logic [6:0]  sy;
    logic [2:0]  sc;
    lat = d + 1;
    n   = r - lat - 2;
    if (d == 0) begin
      sb = busy_a; sd = done_a; sp = plot_a; ss = rsel_a; sa = addr_a; sx = x_a; sy = y_a; sc = col_a;
    end else begin
      sb = busy_b; sd = done_b; sp = plot_b; ss = rsel_b; sa = addr_b; sx = x_b; sy = y_b; sc = col_b;
    end
    if (sb !== ((r <= NPIX + 2 + lat) ? 1'b1 : 1'b0)) e_busy[d]++;
    if (sd !== ((r == NPIX + 2 + lat) ? 1'b1 : 1'b0)) e_done[d]++;
    if (sd === 1'b1) n_done[d]++;
    ea = (r <= NPIX) ? r - 1 : NPIX - 1;
    if (sa !== 15'(ea)) e_addr[d]++;
    if (ss !== 2'(sel_exp[d])) e_sel[d]++;
    if (sp === 1'b1) n_plot[d]++;
    if (n >= 0 && n < NPIX) begin
      if (sp !== 1'b1) e_plot[d]++;
      else begin
        if (sx !== 8'(n % W) || sy !== 7'(n / W)) e_xy[d]++;
        ec = (sel_exp[d] == 3) ? 3'd0 : col_of(rmode[d], n);
        if (sc !== ec) e_col[d]++;
      end
    end else if (sp !== 1'b0) e_plot[d]++;
  endtask

  // One frame (or a back-to-back pair) on both instances. repulse_at > 0
  // re-pulses start with another screen_sel mid-frame; abort_at > 0 applies
  // a one-cycle reset after that cycle.
  task automatic run_frame(input int sel, input int mode, input bit b2b,
                           input int sel2, input int mode2, input int repulse_at,
                           input int repulse_sel, input int abort_at, input string tag);
    int  kmax, nframes, lat, r;
    bit  pend [2];
    bit  aborted;
    aborted = 1'b0;
    for (int d = 0; d < 2; d++) begin
      e_busy[d] = 0; e_done[d] = 0; e_addr[d] = 0; e_plot[d] = 0; e_xy[d] = 0;
      e_col[d] = 0; e_sel[d] = 0; n_plot[d] = 0; n_done[d] = 0; off[d] = 0;
      sel_exp[d] = sel; rmode[d] = mode; pend[d] = b2b;
    end
    repeat ($urandom_range(1, 4)) @(negedge clock);
    screen_sel = 2'(sel);
    start_a = 1'b1;
    start_b = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    nframes = b2b ? 2 : 1;
    kmax    = nframes * (NPIX + 5) + 2;
    for (int k = 1; k <= kmax; k++) begin
      for (int d = 0; d < 2; d++) check_cycle(d, k - off[d]);
      if (k == abort_at) begin
        aborted = 1'b1;
        break;
      end
      start_a = 1'b0;
      start_b = 1'b0;
      if (k == repulse_at) begin
        screen_sel = 2'(repulse_sel);
        start_a = 1'b1;
        start_b = 1'b1;
      end
      for (int d = 0; d < 2; d++) begin
        lat = d + 1;
        r   = k - off[d];
        // Start held through the done cycle (ignored) and the idle cycle after it.
        if (pend[d] && (r == NPIX + 2 + lat || r == NPIX + 3 + lat)) begin
          if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        end
        if (pend[d] && r == NPIX + 3 + lat) begin
          screen_sel = 2'(sel2);
          rmode[d]   = mode2;
          sel_exp[d] = sel2;
          off[d]     = off[d] + NPIX + 3 + lat;
          pend[d]    = 1'b0;
        end
      end
      @(posedge clock);
      @(negedge clock);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    if (aborted) begin
      reset_n = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk_reset({tag, ".after_reset"});
      reset_n = 1'b1;
      repeat (3) begin
        @(posedge clock);
        @(negedge clock);
        if (plot_a !== 1'b0 || busy_a !== 1'b0) e_plot[0]++;
        if (plot_b !== 1'b0 || busy_b !== 1'b0) e_plot[1]++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      lat = d + 1;
      chk($sformatf("%s.plots[%0d]", tag, d), n_plot[d], aborted ? abort_at - lat - 1 : nframes * NPIX);
      chk($sformatf("%s.dones[%0d]", tag, d), n_done[d], aborted ? 0 : nframes);
      chk($sformatf("%s.busy_err[%0d]", tag, d), e_busy[d], 0);
      chk($sformatf("%s.done_err[%0d]", tag, d), e_done[d], 0);
      chk($sformatf("%s.addr_err[%0d]", tag, d), e_addr[d], 0);
      chk($sformatf("%s.plot_err[%0d]", tag, d), e_plot[d], 0);
      chk($sformatf("%s.xy_err[%0d]", tag, d), e_xy[d], 0);
      chk($sformatf("%s.colour_err[%0d]", tag, d), e_col[d], 0);
      chk($sformatf("%s.romsel_err[%0d]", tag, d), e_sel[d], 0);
    end
  endtask

  initial begin
    int rsel;
    for (int i = 0; i < NPIX; i++) rom_tab[i] = int'($urandom_range(0, 7));
    rmode[0] = 0;
    rmode[1] = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset("por");
    reset_n = 1'b1;
    @(negedge clock);

    // Splash frame followed back-to-back by a clear frame (ROM drives 111).
    run_frame(0, 0, 1'b1, 3, 1, -1, 0, -1, "splash_clear");

    // Random screen, ignored re-pulse, then reset around pixel 5000.
    rsel = int'($urandom_range(0, 3));
    run_frame(rsel, 2, 1'b0, 0, 0, 3002, (rsel + 1) % 4, 5002, "reset_mid");

    // Full frame after reset: death screen with a victory re-pulse ignored.
    run_frame(2, 2, 1'b0, 0, 0, 5002, 1, -1, "ignored");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
